fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Program counter and fetch sequencer feeding the 9-bit instruction decoder (control).
//  Drives the instruction-ROM address and sequences PC: increment, or an absolute jump
//  through a 16-entry jump-target LUT. Decoder supplies pc_jmp_en and LutPointer.
//  Adds start/done handshake, halt detection and a cycle counter for benchmarking.
// PARAMETERS
//  PC_W        10       PC / ROM address width; ROM depth = 2**PC_W
//  HALT_INSTR  9'h1FF   encoding that ends the program
//  CYC_W       16       cycle counter width
// PORTS
//  Clk          in   1     clock; all state updates on rising edge
//  Reset        in   1     synchronous, active-high reset
//  start        in   1     one-cycle pulse; begins execution from PC 0
//  instr        in   9     ROM data at prog_ctr (combinational ROM read)
//  pc_jmp_en    in   1     from control: take jump this cycle
//  LutPointer   in   4     from control: jump-LUT index
//  lut_wr_en    in   1     LUT programming strobe (honoured in IDLE/DONE only)
//  lut_wr_addr  in   4     LUT entry to write
//  lut_wr_data  in   PC_W  jump target to store
//  prog_ctr     out  PC_W  ROM address of current instruction
//  running      out  1     high while the current instr is architecturally live
//  done         out  1     level; high in DONE until next start or Reset
//  cycles       out  CYC_W executed-instruction count for last/current run
// BEHAVIOUR
//  States: IDLE, RUN, DONE. Reset -> IDLE, prog_ctr=0, cycles=0, done=0,
//   running=0, all 16 LUT entries = 0.
//  IDLE: prog_ctr holds 0. start -> RUN next cycle, prog_ctr=0, cycles=0.
//  RUN: running=1. Per cycle, in priority order:
//   1. instr==HALT_INSTR -> DONE; prog_ctr holds; cycles not incremented;
//      pc_jmp_en ignored.
//   2. pc_jmp_en=1 -> prog_ctr <= lut[LutPointer] (absolute target).
//   3. prog_ctr==2**PC_W-1 (end of ROM, no jump) -> DONE; PC does not wrap.
//   4. else prog_ctr <= prog_ctr+1.
//   For cases 2-4, cycles <= cycles+1, saturating at all-ones.
//  DONE: done=1, running=0, prog_ctr and cycles hold. start -> RUN, prog_ctr=0,
//   cycles=0, done drops the next cycle.
//  start while in RUN ignored. Reset has priority over everything, including mid-run.
//  LUT: synchronous write, visible the next cycle. Writes during RUN dropped.
//   Read is combinational on LutPointer. A write and a jump in the same cycle cannot
//   coincide (write only outside RUN).
//  Zero-cycle fetch latency: instr must belong to prog_ctr in the same cycle.
//  Jump target may equal current PC (tight loop), which is legal.
// TESTING
//  1. Reset, start, straight-line ROM with HALT at addr 5 -> prog_ctr 0..5; done high
//     cycle after addr 5 seen; cycles==5.
//  2. LUT[3]=0x040 in IDLE; jmp (pc_jmp_en=1, LutPointer=3) at PC 2 -> next prog_ctr
//     0x040, cycles counts jump.
//  3. lut_wr_en during RUN (addr 3, data 0x100) -> later jump via 3 still lands 0x040.
//  4. No HALT in ROM, PC_W=4 -> runs 0..15 then DONE at 15; prog_ctr never shows 0
//     after 15.
//  5. Reset asserted mid-run at PC 7 -> next cycle IDLE, prog_ctr 0, done 0,
//     cycles 0, LUT cleared.
//  6. HALT instr with pc_jmp_en=1 simultaneously -> DONE, no jump; start again ->
//     prog_ctr 0, done low next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and fetch sequencer for the 9-bit instruction
// decoder. Sequences the instruction-ROM address by increment or by absolute
// jump through a 16-entry target LUT. It also provides a start/done handshake,
// halt detection and an executed-instruction counter.
module fetch_unit #(
    parameter int             PC_W       = 10,
    parameter logic [8:0]     HALT_INSTR = 9'h1FF,
    parameter int             CYC_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [8:0]        instr,
    input  logic              pc_jmp_en,
    input  logic [3:0]        LutPointer,
    input  logic              lut_wr_en,
    input  logic [3:0]        lut_wr_addr,
    input  logic [PC_W-1:0]   lut_wr_data,
    output logic [PC_W-1:0]   prog_ctr,
    output logic              running,
    output logic              done,
    output logic [CYC_W-1:0]  cycles
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [PC_W-1:0]  PC_LAST = '1;
    localparam logic [CYC_W-1:0] CYC_MAX = '1;

    logic [1:0]       r_state;
    logic [PC_W-1:0]  r_pc;
    logic [CYC_W-1:0] r_cycles;
    logic [PC_W-1:0]  r_lut [16];

    logic [1:0]       w_state_nxt;
    logic [PC_W-1:0]  w_pc_nxt;
    logic [CYC_W-1:0] w_cycles_nxt;
    logic [CYC_W-1:0] w_cycles_inc;
    logic [PC_W-1:0]  w_jmp_target;
    logic             w_lut_wr;

    // Jump target is read combinationally so a jump resolves in the same cycle.
    assign w_jmp_target = r_lut[LutPointer];

    // The counter sticks at all-ones rather than wrapping on very long runs.
    assign w_cycles_inc = (r_cycles == CYC_MAX) ? r_cycles : r_cycles + CYC_W'(1);

    // The LUT is only programmable while no program is executing.
    assign w_lut_wr = lut_wr_en && (r_state != RUN);

    // Next-state / next-PC selection; halt beats jump, jump beats end-of-ROM.
    always_comb begin
        // NOTE: every output gets a default up front so no path infers a latch.
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_cycles_nxt = r_cycles;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt  = RUN;
                    w_pc_nxt     = '0;
                    w_cycles_nxt = '0;
                end
            end
            RUN: begin
                if (instr == HALT_INSTR) begin
                    w_state_nxt = DONE;
                end else begin
                    w_cycles_nxt = w_cycles_inc;
                    if (pc_jmp_en) begin
                        w_pc_nxt = w_jmp_target;
                    end else if (r_pc == PC_LAST) begin
                        // End of ROM: stop here instead of wrapping to 0.
                        w_state_nxt = DONE;
                    end else begin
                        w_pc_nxt = r_pc + PC_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_pc_nxt     = '0;
                w_cycles_nxt = '0;
            end
        endcase
    end

    // Sequencer state, PC and cycle counter registers.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (Reset) begin
            r_state  <= IDLE;
            r_pc     <= '0;
            r_cycles <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_cycles <= w_cycles_nxt;
        end
    end

    // Jump-target LUT storage with synchronous write.
    always_ff @(posedge Clk) begin
        // NOTE: the LUT is deliberately cleared on reset so a jump through an
        // unprogrammed entry lands at address 0; it is kept small for that reason.
        if (Reset) begin
            for (int i = 0; i < 16; i++) begin
                r_lut[i] <= '0;
            end
        end else if (w_lut_wr) begin
            r_lut[lut_wr_addr] <= lut_wr_data;
        end
    end

    assign prog_ctr = r_pc;
    assign running  = (r_state == RUN);
    assign done     = (r_state == DONE);
    assign cycles   = r_cycles;

endmodule
